// File: rtl/bp_dma_mem_tester.sv
// Self-checking DMA traffic generator for the bsg_cache DRAM back-end interface.
// Writes seeded bursts, reads them back, counts mismatching beats.
module bp_dma_mem_tester #(
  parameter int addr_width_p    = 28,
  parameter int data_width_p    = 64,
  parameter int burst_len_p     = 8,
  parameter int num_bursts_p    = 16,
  parameter int base_addr_p     = 'h100,
  parameter int err_cnt_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic [1:0]                 mode_i,
  input  logic [31:0]                seed_i,
  output logic [addr_width_p:0]      dma_pkt_o,
  output logic                       dma_pkt_v_o,
  input  logic                       dma_pkt_yumi_i,
  output logic [data_width_p-1:0]    dma_data_o,
  output logic                       dma_data_v_o,
  input  logic                       dma_data_yumi_i,
  input  logic [data_width_p-1:0]    dma_data_i,
  input  logic                       dma_data_v_i,
  output logic                       dma_data_ready_and_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic [err_cnt_width_p-1:0] err_count_o,
  output logic [addr_width_p-1:0]    first_err_addr_o
);

  localparam int LANES  = data_width_p / 32;
  localparam int STRIDE = burst_len_p * data_width_p / 8;
  localparam int BW = (num_bursts_p > 1) ? $clog2(num_bursts_p) : 1;
  localparam int LW = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PKT,
    S_WR_DATA,
    S_RD_PKT,
    S_RD_DATA,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 mode_q, mode_d;
  logic [31:0]                seed_q, seed_d;
  logic [BW-1:0]              burst_q, burst_d;
  logic [LW-1:0]              beat_q, beat_d;
  logic [err_cnt_width_p-1:0] err_q, err_d;
  logic [addr_width_p-1:0]    ferr_q, ferr_d;

  logic [addr_width_p-1:0] pkt_addr;
  logic [data_width_p-1:0] exp_data;
  logic [31:0]             g_idx;
  logic [31:0]             lane_base;
  logic                    last_beat;
  logic                    last_burst;
  logic                    wnr;
  logic                    err_full;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      seed_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign pkt_addr = addr_width_p'(base_addr_p)
                  + addr_width_p'(burst_q) * addr_width_p'(STRIDE);

  // Lane j of global beat g carries seed + g*LANES + j.
  always_comb begin
    g_idx     = 32'(burst_q) * 32'(burst_len_p) + 32'(beat_q);
    lane_base = seed_q + g_idx * 32'(LANES);
    exp_data  = '0;
    for (int j = 0; j < LANES; j++) begin
      exp_data[j*32 +: 32] = lane_base + 32'(j);
    end
  end

  assign last_beat  = (beat_q == LW'(burst_len_p - 1));
  assign last_burst = (burst_q == BW'(num_bursts_p - 1));
  assign err_full   = &err_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    wnr     = 1'b0;
    dma_pkt_v_o          = 1'b0;
    dma_data_v_o         = 1'b0;
    dma_data_ready_and_o = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          mode_d  = mode_i;
          seed_d  = seed_i;
          burst_d = '0;
          beat_d  = '0;
          err_d   = '0;
          ferr_d  = '0;
          state_d = (mode_i == 2'd2) ? S_RD_PKT : S_WR_PKT;
        end
      end
      S_WR_PKT: begin
        dma_pkt_v_o = 1'b1;
        wnr         = 1'b1;
        if (dma_pkt_yumi_i) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        dma_data_v_o = 1'b1;
        if (dma_data_yumi_i) begin
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              burst_d = '0;
              state_d = (mode_q == 2'd1) ? S_DONE : S_RD_PKT;
            end else begin
              burst_d = burst_q + 1'b1;
              state_d = S_WR_PKT;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_RD_PKT: begin
        dma_pkt_v_o = 1'b1;
        if (dma_pkt_yumi_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        dma_data_ready_and_o = 1'b1;
        if (dma_data_v_i) begin
          if (dma_data_i != exp_data) begin
            if (!err_full) err_d = err_q + 1'b1;
            if (err_q == '0) ferr_d = pkt_addr;
          end
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              burst_d = '0;
              state_d = S_DONE;
            end else begin
              burst_d = burst_q + 1'b1;
              state_d = S_RD_PKT;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dma_pkt_o        = {wnr, pkt_addr};
  assign dma_data_o       = exp_data;
  assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = done_o && (err_q == '0);
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_q;

endmodule

// File: tb/tb_bp_dma_mem_tester.sv
// Directed bench: default 64x8x16 DUT with a stalling DRAM model,
// plus a 128-bit x4-beat DUT with a zero-wait model.
module tb_bp_dma_mem_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: defaults ----------------
  logic        start_a = 1'b0;
  logic [1:0]  mode_a = '0;
  logic [31:0] seed_a = '0;
  logic [28:0] pkt_a;
  logic        pkt_v_a, pkt_yumi_a;
  logic [63:0] dout_a, din_a;
  logic        dv_a, dyumi_a, dvi_a, rdy_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [27:0] ferr_a;

  bp_dma_mem_tester dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_a),
    .mode_i(mode_a), .seed_i(seed_a),
    .dma_pkt_o(pkt_a), .dma_pkt_v_o(pkt_v_a),
    .dma_pkt_yumi_i(pkt_yumi_a),
    .dma_data_o(dout_a), .dma_data_v_o(dv_a),
    .dma_data_yumi_i(dyumi_a),
    .dma_data_i(din_a), .dma_data_v_i(dvi_a),
    .dma_data_ready_and_o(rdy_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_count_o(err_a), .first_err_addr_o(ferr_a)
  );

  logic        stall_en = 1'b0;
  logic        st_p = 1'b0, st_w = 1'b0, st_r = 1'b0;
  logic        clr = 1'b0;
  logic        flip_en = 1'b0;
  logic [7:0]  flip_g = '0;
  logic [63:0] mem_a [0:255];
  logic [27:0] cur_a;
  logic [28:0] last_pkt_a;
  logic [3:0]  cnt_a;
  logic        rd_act_a;
  logic [7:0]  idx_a;
  int          wr_beats, rd_beats, stab_err;
  logic        pend_p, pend_d;
  logic [28:0] prev_p;
  logic [63:0] prev_d;

  always @(negedge clk) begin
    st_p <= stall_en && ($urandom_range(0, 99) < 30);
    st_w <= stall_en && ($urandom_range(0, 99) < 30);
    st_r <= stall_en && ($urandom_range(0, 99) < 30);
  end

  assign idx_a      = 8'((cur_a - 28'h100) >> 3) + 8'(cnt_a);
  assign pkt_yumi_a = pkt_v_a & ~st_p;
  assign dyumi_a    = dv_a & ~st_w;
  assign dvi_a      = rd_act_a & ~st_r;
  assign din_a      = mem_a[idx_a]
                    ^ ((flip_en && idx_a == flip_g) ? 64'h8 : 64'h0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_act_a <= 1'b0;
      cnt_a    <= '0;
      cur_a    <= '0;
      pend_p   <= 1'b0;
      pend_d   <= 1'b0;
    end else begin
      if (clr) begin
        wr_beats   <= 0;
        rd_beats   <= 0;
        stab_err   <= 0;
        last_pkt_a <= '0;
      end
      if (pkt_v_a && pkt_yumi_a) begin
        cur_a      <= pkt_a[27:0];
        last_pkt_a <= pkt_a;
        cnt_a      <= '0;
        rd_act_a   <= ~pkt_a[28];
      end
      if (dv_a && dyumi_a) begin
        mem_a[idx_a] <= dout_a;
        cnt_a        <= cnt_a + 1'b1;
        wr_beats     <= wr_beats + 1;
      end
      if (dvi_a && rdy_a) begin
        cnt_a    <= cnt_a + 1'b1;
        rd_beats <= rd_beats + 1;
        if (cnt_a == 4'd7) rd_act_a <= 1'b0;
      end
      if (pend_p && (!pkt_v_a || pkt_a != prev_p)) stab_err <= stab_err + 1;
      if (pend_d && (!dv_a || dout_a != prev_d)) stab_err <= stab_err + 1;
      pend_p <= pkt_v_a & ~pkt_yumi_a;
      pend_d <= dv_a & ~dyumi_a;
      prev_p <= pkt_a;
      prev_d <= dout_a;
    end
  end

  // ---------------- DUT B: 128-bit, 4 beats, 4 bursts ----------------
  logic         start_b = 1'b0;
  logic [28:0]  pkt_b;
  logic         pkt_v_b;
  logic [127:0] dout_b, din_b;
  logic         dv_b, rdy_b, busy_b, done_b, pass_b;
  logic [15:0]  err_b;
  logic [27:0]  ferr_b;

  bp_dma_mem_tester #(
    .data_width_p(128), .burst_len_p(4), .num_bursts_p(4)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b),
    .mode_i(2'd0), .seed_i(32'd0),
    .dma_pkt_o(pkt_b), .dma_pkt_v_o(pkt_v_b),
    .dma_pkt_yumi_i(pkt_v_b),
    .dma_data_o(dout_b), .dma_data_v_o(dv_b),
    .dma_data_yumi_i(dv_b),
    .dma_data_i(din_b), .dma_data_v_i(rd_act_b),
    .dma_data_ready_and_o(rdy_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(err_b), .first_err_addr_o(ferr_b)
  );

  logic [127:0] mem_b [0:15];
  logic [27:0]  cur_b;
  logic [28:0]  last_pkt_b;
  logic [2:0]   cnt_b;
  logic         rd_act_b;
  logic [3:0]   idx_b;
  logic [127:0] g1_b;

  assign idx_b = 4'((cur_b - 28'h100) >> 4) + 4'(cnt_b);
  assign din_b = mem_b[idx_b];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_act_b <= 1'b0;
      cnt_b    <= '0;
      cur_b    <= '0;
    end else begin
      if (pkt_v_b) begin
        cur_b      <= pkt_b[27:0];
        last_pkt_b <= pkt_b;
        cnt_b      <= '0;
        rd_act_b   <= ~pkt_b[28];
      end
      if (dv_b) begin
        mem_b[idx_b] <= dout_b;
        cnt_b        <= cnt_b + 1'b1;
        if (idx_b == 4'd1) g1_b <= dout_b;
      end
      if (rd_act_b && rdy_b) begin
        cnt_b <= cnt_b + 1'b1;
        if (cnt_b == 3'd3) rd_act_b <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [31:0] s);
    @(negedge clk);
    clr     = 1'b1;
    mode_a  = m;
    seed_a  = s;
    start_a = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 5000 && !done_a; i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy_a, done_a, pass_a, pkt_v_a, dv_a, rdy_a}, 0);
    chk("reset_err", {ferr_a, err_a}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, seed 0, zero wait
    start_run(2'd0, 32'h0);
    chk("t1_pkt0", {pkt_v_a, pkt_a}, {1'b1, 1'b1, 28'h100});
    @(negedge clk);
    chk("t1_beat0", {dv_a, dout_a}, {1'b1, 64'h00000001_00000000});
    wait_done_a();
    chk("t1_done_pass", {done_a, pass_a, busy_a}, 3'b110);
    chk("t1_err", err_a, 0);
    chk("t1_wr_beats", wr_beats, 128);
    chk("t1_rd_beats", rd_beats, 128);
    chk("t1_last_pkt", last_pkt_a, {1'b0, 28'h4C0});

    // Mode 0, seed DEADBEEF, bit 3 flipped on read beat 21
    flip_en = 1'b1;
    flip_g  = 8'd21;
    start_run(2'd0, 32'hDEADBEEF);
    wait_done_a();
    flip_en = 1'b0;
    chk("t2_err", err_a, 1);
    chk("t2_ferr", ferr_a, 28'h180);
    chk("t2_done_pass", {done_a, pass_a}, 2'b10);

    // Mode 0 with ~30% stalls on every channel
    stall_en = 1'b1;
    start_run(2'd0, 32'h0BADF00D);
    wait_done_a();
    stall_en = 1'b0;
    chk("t3_done_pass", {done_a, pass_a}, 2'b11);
    chk("t3_wr_beats", wr_beats, 128);
    chk("t3_rd_beats", rd_beats, 128);
    chk("t3_stable", stab_err, 0);

    // Mode 1 then mode 2, same seed; then mode 2 with seed+1
    start_run(2'd1, 32'h1234);
    wait_done_a();
    chk("t4_m1_pass", {done_a, pass_a}, 2'b11);
    chk("t4_m1_beats", {wr_beats, rd_beats}, {32'd128, 32'd0});
    chk("t4_m1_last", last_pkt_a, {1'b1, 28'h4C0});
    start_run(2'd2, 32'h1234);
    chk("t4_m2_pkt0", {pkt_v_a, pkt_a}, {1'b1, 1'b0, 28'h100});
    wait_done_a();
    chk("t4_m2_pass", {done_a, pass_a}, 2'b11);
    chk("t4_m2_beats", {wr_beats, rd_beats}, {32'd0, 32'd128});
    start_run(2'd2, 32'h1235);
    wait_done_a();
    chk("t4_bad_err", err_a, 128);
    chk("t4_bad_ferr", ferr_a, 28'h100);
    chk("t4_bad_pass", {done_a, pass_a}, 2'b10);

    // Mode 3 behaves as mode 0
    start_run(2'd3, 32'h5);
    wait_done_a();
    chk("t5_m3_pass", {done_a, pass_a}, 2'b11);
    chk("t5_m3_beats", {wr_beats, rd_beats}, {32'd128, 32'd128});

    // Start while busy is ignored
    start_run(2'd1, 32'h0);
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    mode_a  = 2'd2;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a();
    chk("t6_busy_start", {wr_beats, rd_beats}, {32'd128, 32'd0});

    // Async reset during WR_DATA beat 3
    start_run(2'd0, 32'h0);
    for (int i = 0; i < 100 && !(dv_a && wr_beats == 3); i++)
      @(negedge clk);
    chk("t7_reached", {dv_a, 32'(wr_beats)}, {1'b1, 32'd3});
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_outs", {busy_a, done_a, pass_a, pkt_v_a, dv_a, rdy_a}, 0);
    chk("t7_rst_err", {ferr_a, err_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(2'd0, 32'h77);
    wait_done_a();
    chk("t7_rerun", {done_a, pass_a, err_a}, {2'b11, 16'd0});
    chk("t7_beats", {wr_beats, rd_beats}, {32'd128, 32'd128});

    // 128-bit, 4-beat instance
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("tb_pkt0", {pkt_v_b, pkt_b}, {1'b1, 1'b1, 28'h100});
    for (int i = 0; i < 500 && !done_b; i++) @(negedge clk);
    chk("tb_g1", g1_b, 128'h00000007_00000006_00000005_00000004);
    chk("tb_last", last_pkt_b, {1'b0, 28'h1C0});
    chk("tb_pass", {done_b, pass_b, err_b}, {2'b11, 16'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_dma_mem_tester.md
Name: bp_dma_mem_tester

Overview:
- Synthesizable self-checking traffic generator that masters the bsg_cache DMA interface (pkt / data-out / data-in) of a DRAM back end such as mig_ddr3_ram.
- Used for on-board bring-up and regression of the DDR3 path without a BP core. Generalises the fixed 8x64-bit single-burst check to parametrised data width, burst length and burst count, with run modes, seeded patterns and error reporting.

Parameters:
- addr_width_p, 28: DMA packet address width (caddr).
- data_width_p, 64: DMA data beat width; multiple of 32.
- burst_len_p, 8: beats per DMA packet.
- num_bursts_p, 16: packets per pass.
- base_addr_p, 'h100: byte address of burst 0.
- err_cnt_width_p, 16: error counter width.

Ports:
- clk_i  in  1  core clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; sampled only in IDLE/DONE.
- mode_i  in  2  0 = write then read-check, 1 = write only, 2 = read-check only, 3 = reserved (treated as 0); latched on start.
- seed_i  in  32  pattern seed; latched on start.
- dma_pkt_o  out  1+addr_width_p  {write_not_read, addr}.
- dma_pkt_v_o  out  1  packet valid.
- dma_pkt_yumi_i  in  1  packet accepted.
- dma_data_o  out  data_width_p  write beat.
- dma_data_v_o  out  1  write beat valid.
- dma_data_yumi_i  in  1  write beat accepted.
- dma_data_i  in  data_width_p  read beat.
- dma_data_v_i  in  1  read beat valid.
- dma_data_ready_and_o  out  1  read beat ready.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; sticky until next start.
- pass_o  out  1  done with zero errors.
- err_count_o  out  err_cnt_width_p  mismatching beats, saturating.
- first_err_addr_o  out  addr_width_p  packet address of first mismatching beat.

Behaviour:
- Reset (async assert, sync-deassert handled upstream): state IDLE; all valids, ready, busy_o, done_o and pass_o = 0; err_count_o = 0; first_err_addr_o = 0; counters = 0.
- States: IDLE, WR_PKT, WR_DATA, RD_PKT, RD_DATA, DONE.
- start_i in IDLE/DONE:
  - Latch mode and seed; clear done, pass, errors and counters; busy_o = 1.
  - Next state is WR_PKT for modes 0, 1 and 3; RD_PKT for mode 2.
- WR_PKT:
  - dma_pkt_v_o = 1, write_not_read = 1, addr = base_addr_p + burst*(burst_len_p*data_width_p/8), mod 2^addr_width_p.
  - Packet fields are held stable until dma_pkt_yumi_i; then go to WR_DATA.
- WR_DATA:
  - dma_data_v_o = 1 with the pattern beat; advance beat on dma_data_yumi_i.
  - After beat burst_len_p-1: burst++. If more bursts remain, go to WR_PKT. Otherwise go to RD_PKT (mode 0/3) or DONE (mode 1), and reset the burst counter.
- RD_PKT / RD_DATA:
  - RD_PKT mirrors WR_PKT with write_not_read = 0.
  - In RD_DATA, dma_data_ready_and_o = 1; a beat is consumed when dma_data_v_i & ready.
  - Compare each consumed beat with the expected pattern. On mismatch, err_count_o increments, saturating at all-ones. On the first mismatch only, capture first_err_addr_o.
  - Burst sequencing is identical to the write side; after the last burst go to DONE.
- Ready is 0 outside RD_DATA. Read beats presented at other times are not consumed and are not errors.
- DONE: busy_o = 0, done_o = 1, pass_o = (err_count_o == 0). Mode 1 always gives pass_o = 1.
- Pattern: beat index g = burst*burst_len_p + beat. 32-bit lane j (lane 0 = LSBs) = seed + g*(data_width_p/32) + j, mod 2^32.
- Latency: at most one cycle of state change between handshakes; the block never waits an extra cycle after a yumi. Valid is reasserted combinationally from state, with no bubble beyond the one-cycle state transition.
- start_i while busy: ignored. Simultaneous start_i and final-beat handshake: the handshake completes and the run ends in DONE; start_i is ignored.
- Reset mid-run: immediate abort to IDLE. A partially transferred burst is abandoned; the DRAM side must also be reset.

Test Plan:
- Mode 0, seed 0, defaults, zero-wait memory model: 16 packets at addrs 0x100, 0x140, ... 0x4C0, writes then reads. Burst 0 beat 0 = 0x00000001_00000000. Expect done_o = 1, pass_o = 1, err_count_o = 0.
- Mode 0, seed 0xDEADBEEF, model flips bit 3 of read beat g = 21 (burst 2, beat 5). Expect err_count_o = 1, first_err_addr_o = 0x180, pass_o = 0.
- Random yumi/valid backpressure (about 30% stall) on all three channels, mode 0: packet fields and data stay stable while unaccepted. Expect pass_o = 1 and exactly 128 beats each way.
- Mode 1 then mode 2 with the same seed 0x1234: mode 2 issues only read packets. Expect pass_o = 1. Repeat mode 2 with seed 0x1235: expect err_count_o = 128.
- data_width_p = 128, burst_len_p = 4: stride 0x40. Beat g = 1 lanes = 0x...07, 06, 05, 04 (seed 0). Expect pass_o = 1.
- Assert reset_n_i low during WR_DATA beat 3: all outputs drop to reset values asynchronously. A subsequent start_i runs cleanly.
